// File: rtl/wb_scoreboard_pkg.sv
// Shared register-index types and long-latency opcode classification for the
// writeback scoreboard and the decode logic that drives issue_long.
package wb_scoreboard_pkg;

  localparam int REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

  typedef enum logic [6:0] {
    OPC_LOAD    = 7'b0000011,
    OPC_OP_IMM  = 7'b0010011,
    OPC_STORE   = 7'b0100011,
    OPC_OP      = 7'b0110011,
    OPC_CUSTOM0 = 7'b0001011
  } opcode_e;

  // Loads and the custom multi-cycle unit complete in WB, past the X bypass.
  function automatic logic is_long_opc(input logic [6:0] opc);
    return (opc == OPC_LOAD) || (opc == OPC_CUSTOM0);
  endfunction

endpackage

// File: rtl/wb_scoreboard_tag_fifo.sv
// In-order completion queue of destination tags for outstanding long ops.
// Illegal pushes (full, no pop) and pops (empty) are dropped and flagged on err.
module wb_scoreboard_tag_fifo
  import wb_scoreboard_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [4:0]       din,
  output logic [4:0]       head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  reg_idx_t         mem [DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    empty   = (cnt_q == '0);
    full    = (cnt_q == CNT_W'(DEPTH));
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    err     = (pop && empty) || (push && full && !do_pop);
    head    = mem[head_ptr];
    count   = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[tail_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) tail_ptr <= next_ptr(tail_ptr);
      if (do_pop)  head_ptr <= next_ptr(head_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard for long-latency ops: records destinations at issue,
// retires them at writeback, and stalls ID on hazards no bypass can cover.
module wb_scoreboard
  import wb_scoreboard_pkg::*;
#(
  parameter int MAX_OUT = 2,
  parameter int CNT_W   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic             issue_long,
  input  logic             issue_wen,
  input  logic [4:0]       issue_rd,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             rs1_used,
  input  logic             rs2_used,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  output logic             stall_ID,
  output logic             issue_accept,
  output logic [31:0]      pending,
  output logic [CNT_W-1:0] outstanding_cnt,
  output logic             full,
  output logic             sb_err
);

  logic [31:0]      pending_q;
  logic [31:0]      pending_next;
  logic [31:0]      retire_mask;
  logic [31:0]      p_eff;
  logic [31:0]      set_mask;
  logic [31:0]      clr_mask;
  logic             sb_err_q;
  logic             retire;
  logic             push;
  logic             tag_valid;
  logic             mismatch;
  reg_idx_t         push_tag;
  reg_idx_t         fifo_head;
  logic [CNT_W-1:0] fifo_cnt;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_err;

  wb_scoreboard_tag_fifo #(
    .DEPTH (MAX_OUT),
    .CNT_W (CNT_W)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (wb_valid),
    .din   (push_tag),
    .head  (fifo_head),
    .count (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty),
    .err   (fifo_err)
  );

  always_comb begin
    retire      = wb_valid && !fifo_empty;
    retire_mask = (retire && wb_rd != REG_ZERO) ? (32'd1 << wb_rd) : 32'd0;
    // The retiring value is visible through the WB bypass this cycle.
    p_eff       = pending_q & ~retire_mask;

    stall_ID    = (rs1_used && rs1_ID != REG_ZERO && p_eff[rs1_ID])
               || (rs2_used && rs2_ID != REG_ZERO && p_eff[rs2_ID])
               || (issue_valid && issue_wen && issue_rd != REG_ZERO && p_eff[issue_rd])
               || (issue_valid && issue_long && fifo_full && !retire);
    issue_accept = issue_valid && !stall_ID;

    tag_valid   = issue_wen && issue_rd != REG_ZERO;
    push        = issue_accept && issue_long;
    push_tag    = tag_valid ? issue_rd : REG_ZERO;

    set_mask    = (push && tag_valid) ? (32'd1 << issue_rd) : 32'd0;
    clr_mask    = (retire && fifo_head != REG_ZERO) ? (32'd1 << fifo_head) : 32'd0;
    // A new write to the register being retired keeps its pending bit.
    pending_next = ((pending_q & ~clr_mask) | set_mask) & ~32'd1;

    mismatch    = retire && (wb_rd != fifo_head);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= 32'd0;
      sb_err_q  <= 1'b0;
    end else begin
      pending_q <= pending_next;
      sb_err_q  <= sb_err_q | fifo_err | mismatch;
    end
  end

  assign pending         = pending_q;
  assign outstanding_cnt = fifo_cnt;
  assign full            = fifo_full;
  assign sb_err          = sb_err_q;

endmodule
